// File: rtl/uart_pkg.sv
// Shared UART definitions for uart_tx / uart_rx: FSM states, oversampling default, baud divisors.
// Pure declarations; no logic, no latency, no backpressure.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 8;

  // 50 MHz core clock, 9600 baud; the receive divisor yields 8x ticks
  localparam int BAUD_DIV_TX = 5208;
  localparam int BAUD_DIV_RX = 651;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs, reset to all-ones (idle line level).
// Latency 2 clk cycles; no backpressure.
module uart_rx_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start validation at mid-bit, LSB-first data, stop check, valid/ready output.
// Outputs register one clk after the stop-centre tick; a held byte blocks new ones (overrun pulse).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 armed_q, armed_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  uart_rx_sync #(.WIDTH(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_serial),
    .q_o (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    armed_d = armed_q;
    valid_d = valid_q && !rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (baud_tick) begin
      // A start is only believed after the line has been seen high, so a break yields one error
      if (rx_s) armed_d = 1'b1;
      tcnt_d = tcnt_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          if (armed_q && !rx_s) begin
            state_d = ST_START;
            tcnt_d  = '0;
            armed_d = 1'b0;
          end
        end
        ST_START: begin
          if (tcnt_q == T_HALF) begin
            state_d = rx_s ? ST_IDLE : ST_DATA;
            tcnt_d  = '0;
          end
        end
        ST_DATA: begin
          if (tcnt_q == T_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bcnt_q == B_LAST) begin
              state_d = ST_STOP;
              tcnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (tcnt_q == T_LAST) begin
            state_d = ST_IDLE;
            tcnt_d  = '0;
            if (!rx_s) begin
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end else if (!valid_q || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      armed_q <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      armed_q <= armed_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: scoreboard of expected events (bytes, frame errors, overruns) popped by a monitor.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int  HALF_CLK = 50;
  localparam int  TICK_T   = 2 * HALF_CLK * 2;   // baud_tick every second clk
  localparam real BIT_T    = 8.0 * TICK_T;       // nominal bit period, 8 ticks

  localparam int EV_DATA = 0;
  localparam int EV_FERR = 1;
  localparam int EV_OVR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_ph = 1'b0;
  logic       baud_tick;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  ovr_cyc = -1;
  ev_t exp_q[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick    (baud_tick),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #(HALF_CLK) clk = ~clk;
  always @(posedge clk) begin
    tick_ph <= ~tick_ph;
    cyc     <= cyc + 1;
  end
  assign baud_tick = tick_ph;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind=%0d data=%02h expected none", kind, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == EV_DATA)
        chk("event", 32'(kind * 256) + 32'(data), 32'(e.kind * 256) + 32'(e.data));
      else
        chk("event_kind", 32'(kind), 32'(e.kind));
    end
  endtask

  // Monitor: a transfer is valid&&ready seen just before the clock edge that consumes it
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_ready) pop_chk(EV_DATA, rx_data);
      if (rx_frame_err)         pop_chk(EV_FERR, 8'h00);
      if (rx_overrun) begin
        ovr_cyc = cyc;
        pop_chk(EV_OVR, 8'h00);
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input real bt);
    rx_serial = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      #(bt);
    end
    rx_serial = stop_v;
    #(bt);
  endtask

  task automatic sync_to_tick();
    do @(negedge clk); while (!baud_tick);
  endtask

  task automatic accept_one();
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] last_data;
    int t1;
    int t2;
    int target;
    real bt;
    logic [7:0] b;

    rst       = 1'b1;
    rx_serial = 1'b1;
    rx_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data",  32'(rx_data), 32'h0);
    chk("reset_valid", 32'(rx_valid), 32'h0);
    chk("reset_ferr",  32'(rx_frame_err), 32'h0);
    chk("reset_ovr",   32'(rx_overrun), 32'h0);
    chk("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;
    repeat (20) @(negedge clk);
    last_data = 8'h00;

    // Single byte held until accepted
    sync_to_tick();
    fork
      send_frame(8'h41, 1'b1, BIT_T);
      begin
        #(BIT_T * 9.0 + 10.0);
        chk("t1_valid_before_stop", 32'(rx_valid), 32'h0);
      end
    join
    chk("t1_valid", 32'(rx_valid), 32'h1);
    chk("t1_data",  32'(rx_data), 32'h41);
    repeat (50) @(negedge clk);
    chk("t1_valid_held", 32'(rx_valid), 32'h1);
    chk("t1_data_held",  32'(rx_data), 32'h41);
    push_ev(EV_DATA, 8'h41);
    accept_one();
    @(negedge clk);
    chk("t1_valid_drop", 32'(rx_valid), 32'h0);
    last_data = 8'h41;

    // Short low glitch: rejected at the start-bit centre
    rx_serial = 1'b0;
    #(2 * TICK_T);
    rx_serial = 1'b1;
    #(BIT_T * 3.0);
    chk("glitch_valid", 32'(rx_valid), 32'h0);
    chk("glitch_data",  32'(rx_data), 32'(last_data));

    // Frame error, then break, then recovery
    rx_ready = 1'b1;
    push_ev(EV_FERR, 8'h00);
    send_frame(8'h55, 1'b0, BIT_T);
    #(40 * TICK_T);
    chk("ferr_valid", 32'(rx_valid), 32'h0);
    chk("ferr_data",  32'(rx_data), 32'(last_data));
    rx_serial = 1'b1;
    #(BIT_T);
    push_ev(EV_DATA, 8'h0F);
    send_frame(8'h0F, 1'b1, BIT_T);
    #(BIT_T * 2.0);
    last_data = 8'h0F;
    chk("recov_data", 32'(rx_data), 32'(last_data));

    // Back-to-back with consumer stalled: second byte overruns
    rx_ready = 1'b0;
    push_ev(EV_OVR, 8'h00);
    sync_to_tick();
    t1 = cyc;
    send_frame(8'hA5, 1'b1, BIT_T);
    send_frame(8'h3C, 1'b1, BIT_T);
    #(BIT_T);
    chk("ovr_valid", 32'(rx_valid), 32'h1);
    chk("ovr_data",  32'(rx_data), 32'hA5);
    push_ev(EV_DATA, 8'hA5);
    accept_one();
    @(negedge clk);
    chk("ovr_valid_drop", 32'(rx_valid), 32'h0);

    // Same sequence, accepting exactly in the cycle where the second byte completes
    chk("ovr_seen", 32'(ovr_cyc >= 0), 32'h1);
    push_ev(EV_DATA, 8'hA5);
    sync_to_tick();
    t2 = cyc;
    target = t2 + (ovr_cyc - t1) - 2;
    fork
      begin
        send_frame(8'hA5, 1'b1, BIT_T);
        send_frame(8'h3C, 1'b1, BIT_T);
      end
      begin
        while (cyc < target) @(negedge clk);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
      end
    join
    #(BIT_T);
    chk("simul_valid", 32'(rx_valid), 32'h1);
    chk("simul_data",  32'(rx_data), 32'h3C);
    push_ev(EV_DATA, 8'h3C);
    accept_one();
    @(negedge clk);
    chk("simul_valid_drop", 32'(rx_valid), 32'h0);

    // Reset during data bit 4
    sync_to_tick();
    fork
      send_frame(8'hFF, 1'b1, BIT_T);
      begin
        #(BIT_T * 5.5);
        rst = 1'b1;
        #1;
        chk("mrst_data",  32'(rx_data), 32'h0);
        chk("mrst_valid", 32'(rx_valid), 32'h0);
        chk("mrst_ferr",  32'(rx_frame_err), 32'h0);
        chk("mrst_ovr",   32'(rx_overrun), 32'h0);
        chk("mrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        #(2 * HALF_CLK * 2 - 1);
        rst = 1'b0;
      end
    join
    #(BIT_T * 2.0);
    chk("mrst_no_valid", 32'(rx_valid), 32'h0);
    rx_ready = 1'b1;
    push_ev(EV_DATA, 8'h81);
    send_frame(8'h81, 1'b1, BIT_T);
    #(BIT_T * 2.0);
    chk("mrst_next_data", 32'(rx_data), 32'h81);

    // Random bytes with up to +-2% baud skew
    for (int n = 0; n < 256; n++) begin
      b  = 8'($urandom_range(0, 255));
      bt = BIT_T * (1.0 + (real'($urandom_range(0, 400)) - 200.0) / 10000.0);
      push_ev(EV_DATA, b);
      send_frame(b, 1'b1, bt);
      #(10 * $urandom_range(2, 24));
    end
    #(BIT_T * 3.0);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

8x-oversampling UART receiver, the receive-side counterpart of `uart_tx`, fed by the existing `baud_generator` instance configured for 8x (`BAUD_DIV` 651 at 50 MHz / 9600 baud). It synchronises the serial input, detects and validates the start bit, and samples data bits at their centres, LSB first. It checks the stop bit and presents each received byte on a valid/ready handshake toward the top-level logic. Frame-error and overrun are reported as one-cycle pulses.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame; LSB first; no parity.
- `OVERSAMPLE`, 8: `baud_tick` pulses per bit period; must be a power of 2 and at least 4.

Ports:
- `clk`  in  1  single system clock; the only clock in the block.
- `rst`  in  1  reset, asynchronous and active-high.
- `baud_tick`  in  1  one-`clk`-wide pulse at `OVERSAMPLE` × baud rate, from `baud_generator`.
- `rx_serial`  in  1  asynchronous UART line; idle high.
- `rx_data`  out  `DATA_BITS`  received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts; a transfer occurs when `rx_valid && rx_ready`.
- `rx_frame_err`  out  1  one-cycle pulse when the stop bit samples low.
- `rx_overrun`  out  1  one-cycle pulse when a good byte completes while `rx_valid` is still held.

## Operation
- Input path: `rx_serial` → 2-flop synchroniser, flops reset to 1 → `rx_s`. All line sampling uses `rx_s`, and only in cycles where `baud_tick` = 1.
- Tick counter `tcnt`, log2(`OVERSAMPLE`) bits: increments on each tick, wraps, and clears to 0 on every state change.
- Bit counter `bcnt`: counts received data bits, 0 .. `DATA_BITS`-1.
- `armed` flag:
  - Set on any tick where `rx_s` = 1.
  - Cleared on entry to START.
  - Cleared after a frame error.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START on a tick with `armed` = 1 and `rx_s` = 0.
- START: on the tick where `tcnt` = `OVERSAMPLE`/2-1 (the bit centre):
  - `rx_s` = 0 → DATA.
  - `rx_s` = 1 → IDLE. This is a glitch rejection; no outputs change.
- DATA: on the tick where `tcnt` = `OVERSAMPLE`-1:
  - Shift `rx_s` into the MSB of the shift register (a right shift, giving LSB-first order).
  - Increment `bcnt`.
  - After bit `DATA_BITS`-1, go to STOP.
- STOP: on the tick where `tcnt` = `OVERSAMPLE`-1, go to IDLE, with the result depending on the sampled stop bit:
  - `rx_s` = 1 and the output is free or being accepted this cycle: load `rx_data`, set `rx_valid`.
  - `rx_s` = 1 and the output is held (`rx_valid` = 1, `rx_ready` = 0): pulse `rx_overrun`, drop the new byte, leave `rx_data` unchanged.
  - `rx_s` = 0: pulse `rx_frame_err`, discard the byte, leave `rx_valid`/`rx_data` unchanged, clear `armed`.
- `rx_ready` has no effect while `rx_valid` = 0.

## Timing
- Reset values:
  - `rx_data` = 0; `rx_valid`, `rx_frame_err`, `rx_overrun` = 0.
  - State IDLE; `tcnt`, `bcnt` = 0; `armed` = 0; synchroniser flops = 1.
- `rst` clears everything immediately, including mid-frame. After release the receiver needs one tick with `rx_s` high before a new start can be detected.
- Synchroniser latency: 2 `clk` cycles.
- Start-detect to centre of data bit 0: `OVERSAMPLE`/2 + `OVERSAMPLE` ticks (12 at 8x).
- `rx_valid`, `rx_frame_err`, `rx_overrun` are registered. Each rises or pulses in the `clk` cycle after the stop-sample tick.
- The transition to IDLE at the stop-bit centre allows back-to-back frames with no idle gap.
- Handshake: `rx_valid` falls in the cycle after the transfer. Simultaneous accept and new completion: the new byte loads, `rx_valid` stays 1, no overrun.
- Break (line held low): exactly one `rx_frame_err` pulse, then no further activity until the line returns high.
- Clock-count arithmetic is not needed; all timing is in ticks, and the bit period is `OVERSAMPLE` ticks exactly.

## Structure
- Shared package `uart_pkg`, used by `uart_tx` and `uart_rx`:
  - FSM state enum.
  - `OVERSAMPLE` default.
  - Baud divisor constants: `BAUD_DIV_TX` = 5208, `BAUD_DIV_RX` = 651, for 50 MHz / 9600.
- One sub-module, `uart_rx_sync`: a 2-flop synchroniser with reset value 1, parameterised by width.
- `baud_generator` stays external; the top-level instantiates `uart_rx` next to `uart_tx`.

## Test plan
- Send 0x41 framed at 9600 baud, 8x ticks, with `rx_ready` = 0. Required: `rx_data` = 0x41 and `rx_valid` = 1 starting one cycle after the stop-centre tick, held until `rx_ready` pulses, then 0 in the next cycle.
- Pull the line low for 2 ticks, then return it high. Required: START aborts to IDLE; no `rx_valid`, no `rx_frame_err`.
- Send 0x55 with the stop bit forced low. Required: one `rx_frame_err` pulse, `rx_valid` stays 0, `rx_data` unchanged. Then hold the line low for 40 ticks: no further pulses. Then send 0x0F after the line returns high: received correctly.
- Send 0xA5 then 0x3C back-to-back with `rx_ready` = 0. Required: `rx_data` = 0xA5 retained, one `rx_overrun` pulse at the end of 0x3C. Repeat with `rx_ready` = 1 in the completion cycle: `rx_data` = 0x3C, no overrun.
- Assert `rst` mid-way through data bit 4 of 0xFF. Required: all outputs 0 immediately, state IDLE; the rest of the frame produces no `rx_valid`. The next clean 0x81 frame is received correctly.
- Send 256 random bytes with ±2% baud skew on the stimulus. Required: every byte matches and no error pulses occur.
